// File: rtl/display_capture.sv
// display_capture: receiver for the display_decoder serial segment link. It requests bits with next_led,
// rebuilds 7-segment patterns and decodes them to a binary value. Define DISPLAY_CAPTURE_DP_EN to capture dp bits.
module display_capture #(
  parameter int GAP_CYCLES = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  digit_count,
  input  logic        led_data,
  input  logic        busy_in,
  output logic        next_led,
  output logic        busy,
  output logic [15:0] value,
  output logic        valid,
  output logic        error,
  output logic [2:0]  dp_mask
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
`ifdef DISPLAY_CAPTURE_DP_EN
  localparam int PAT_W = 8;
`else
  localparam int PAT_W = 7;  // the dp bit is shifted past the register and lost
`endif

  typedef enum logic [2:0] {IDLE, REQ, WAIT, GAP, DIGIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         dc_q, dc_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [1:0]         digit_cnt_q, digit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [15:0]        acc_q, acc_d;
  logic [15:0]        weight_q, weight_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [15:0]        value_q, value_d;
  logic               error_q, error_d;
  logic [4:0]         dec;
`ifdef DISPLAY_CAPTURE_DP_EN
  logic [2:0]         dp_acc_q, dp_acc_d;
  logic [2:0]         dp_mask_q, dp_mask_d;
`endif

  // Returns {invalid, digit}; unknown patterns decode as digit 0 with the invalid flag set.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   seg_decode = 5'd0;
      7'h06:   seg_decode = 5'd1;
      7'h5B:   seg_decode = 5'd2;
      7'h4F:   seg_decode = 5'd3;
      7'h66:   seg_decode = 5'd4;
      7'h6D:   seg_decode = 5'd5;
      7'h7D:   seg_decode = 5'd6;
      7'h07:   seg_decode = 5'd7;
      7'h7F:   seg_decode = 5'd8;
      7'h6F:   seg_decode = 5'd9;
      default: seg_decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    dc_d        = dc_q;
    bit_cnt_d   = bit_cnt_q;
    digit_cnt_d = digit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    to_cnt_d    = to_cnt_q;
    pattern_d   = pattern_q;
    acc_d       = acc_q;
    weight_d    = weight_q;
    err_d       = err_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    value_d     = value_q;
    error_d     = error_q;
    dec         = seg_decode(pattern_q[6:0]);
`ifdef DISPLAY_CAPTURE_DP_EN
    dp_acc_d    = dp_acc_q;
    dp_mask_d   = dp_mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          dc_d        = digit_count;
          acc_d       = 16'd0;
          weight_d    = 16'd1;
          bit_cnt_d   = 3'd0;
          digit_cnt_d = 2'd0;
          err_d       = 1'b0;
`ifdef DISPLAY_CAPTURE_DP_EN
          dp_acc_d    = 3'b000;
`endif
          if (digit_count != 2'd0) begin
            busy_d  = 1'b1;
            state_d = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      REQ: begin
        to_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (!busy_in) begin
          pattern_d = {pattern_q[PAT_W-2:0], led_data};
          gap_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = DIGIT;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = GAP;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = REQ;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      DIGIT: begin
        if (dec[4]) err_d = 1'b1;
        acc_d    = acc_q + 16'(dec[3:0]) * weight_q;
        weight_d = (weight_q << 3) + (weight_q << 1);
`ifdef DISPLAY_CAPTURE_DP_EN
        dp_acc_d[digit_cnt_q] = pattern_q[7];
`endif
        if (({1'b0, digit_cnt_q} + 3'd1) < {1'b0, dc_q}) begin
          digit_cnt_d = digit_cnt_q + 2'd1;
          bit_cnt_d   = 3'd0;
          gap_cnt_d   = '0;
          state_d     = GAP;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        value_d = acc_q;
        error_d = err_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
`ifdef DISPLAY_CAPTURE_DP_EN
        dp_mask_d = dp_acc_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dc_q        <= 2'd0;
      bit_cnt_q   <= 3'd0;
      digit_cnt_q <= 2'd0;
      gap_cnt_q   <= '0;
      to_cnt_q    <= '0;
      pattern_q   <= '0;
      acc_q       <= 16'd0;
      weight_q    <= 16'd0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      value_q     <= 16'd0;
      error_q     <= 1'b0;
`ifdef DISPLAY_CAPTURE_DP_EN
      dp_acc_q    <= 3'b000;
      dp_mask_q   <= 3'b000;
`endif
    end else begin
      state_q     <= state_d;
      dc_q        <= dc_d;
      bit_cnt_q   <= bit_cnt_d;
      digit_cnt_q <= digit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pattern_q   <= pattern_d;
      acc_q       <= acc_d;
      weight_q    <= weight_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      value_q     <= value_d;
      error_q     <= error_d;
`ifdef DISPLAY_CAPTURE_DP_EN
      dp_acc_q    <= dp_acc_d;
      dp_mask_q   <= dp_mask_d;
`endif
    end
  end

  assign next_led = (state_q == REQ);
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign value    = value_q;
  assign error    = error_q;
`ifdef DISPLAY_CAPTURE_DP_EN
  assign dp_mask  = dp_mask_q;
`else
  assign dp_mask  = 3'b000;
`endif

endmodule
